// File: rtl/clk_rst_ctrl_if.sv
// Control/status bundle of clk_rst_ctrl: software reset and divide ratio in; synchronized reset, divider and uptime out.
interface clk_rst_ctrl_if #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 32
);
  logic                 sw_rst_req;
  logic [DIV_WIDTH-1:0] div_ratio;
  logic                 rst_sync_n;
  logic                 rst_done;
  logic                 clk_div_en;
  logic                 clk_div;
  logic [CNT_WIDTH-1:0] uptime;

  modport master (
    output sw_rst_req, div_ratio,
    input  rst_sync_n, rst_done, clk_div_en, clk_div, uptime
  );

  modport slave (
    input  sw_rst_req, div_ratio,
    output rst_sync_n, rst_done, clk_div_en, clk_div, uptime
  );
endinterface

// File: rtl/clk_rst_ctrl.sv
// Reset synchronizer with hold time, reset-done pulse, programmable clock divider and saturating uptime.
// rst_sync_n releases SYNC_STAGES+HOLD_CYCLES+1 edges after rst rises; all outputs registered, no backpressure.
module clk_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int DIV_WIDTH   = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  clk_rst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [HW-1:0]          hold_cnt, hold_cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;

  logic                   run_q, run_nxt;
  logic                   rst_done_q;
  logic [DIV_WIDTH-1:0]   div_n, div_n_nxt, div_cnt, div_cnt_nxt, eff_n;
  logic [DIV_WIDTH:0]     half_nxt;
  logic                   div_en_q, div_en_nxt, clk_div_q, clk_div_nxt;
  logic [CNT_WIDTH-1:0]   uptime_q, uptime_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RESET;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    if (bus.sw_rst_req) begin
      state_nxt    = ST_HOLD;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (sync_ok) begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
          else                       hold_cnt_nxt = hold_cnt + 1'b1;
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_RESET;
      endcase
    end
  end

  assign run_nxt = (state_nxt == ST_RUN);
  assign eff_n   = (bus.div_ratio > DIV_ONE) ? bus.div_ratio : DIV_ONE;

  // Ratio is captured only on entry to RUN and at each period wrap, so a mid-period change waits its turn.
  always_comb begin
    div_n_nxt   = '0;
    div_cnt_nxt = '0;
    if (run_nxt) begin
      if (!run_q || (div_cnt == div_n - DIV_ONE)) begin
        div_n_nxt   = eff_n;
        div_cnt_nxt = '0;
      end else begin
        div_n_nxt   = div_n;
        div_cnt_nxt = div_cnt + DIV_ONE;
      end
    end
  end

  assign half_nxt    = ({1'b0, div_n_nxt} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
  assign div_en_nxt  = run_nxt && (div_cnt_nxt == div_n_nxt - DIV_ONE);
  assign clk_div_nxt = run_nxt && (div_n_nxt > DIV_ONE) && ({1'b0, div_cnt_nxt} < half_nxt);

  always_comb begin
    uptime_nxt = '0;
    if (run_nxt) begin
      if (!run_q)         uptime_nxt = CNT_ONE;
      else if (&uptime_q) uptime_nxt = uptime_q;
      else                uptime_nxt = uptime_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      rst_done_q <= 1'b0;
      div_n      <= '0;
      div_cnt    <= '0;
      div_en_q   <= 1'b0;
      clk_div_q  <= 1'b0;
      uptime_q   <= '0;
    end else begin
      run_q      <= run_nxt;
      rst_done_q <= run_nxt && !run_q;
      div_n      <= div_n_nxt;
      div_cnt    <= div_cnt_nxt;
      div_en_q   <= div_en_nxt;
      clk_div_q  <= clk_div_nxt;
      uptime_q   <= uptime_nxt;
    end
  end

  assign bus.rst_sync_n = run_q;
  assign bus.rst_done   = rst_done_q;
  assign bus.clk_div_en = div_en_q;
  assign bus.clk_div    = clk_div_q;
  assign bus.uptime     = uptime_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench for clk_rst_ctrl: release latency, software reset, divider patterns, async reset, uptime saturation.
module tb_clk_rst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  clk_rst_ctrl_if #(.DIV_WIDTH(8), .CNT_WIDTH(32)) bus  ();
  clk_rst_ctrl_if #(.DIV_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  clk_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .DIV_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  clk_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .DIV_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(5);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL reset_rst_sync_n got %b want 0", bus.rst_sync_n); else pass_cnt++;
    total_cnt++; if (bus.rst_done !== 1'b0) $display("FAIL reset_rst_done got %b want 0", bus.rst_done); else pass_cnt++;
    total_cnt++; if (bus.clk_div_en !== 1'b0) $display("FAIL reset_clk_div_en got %b want 0", bus.clk_div_en); else pass_cnt++;
    total_cnt++; if (bus.clk_div !== 1'b0) $display("FAIL reset_clk_div got %b want 0", bus.clk_div); else pass_cnt++;
    total_cnt++; if (bus.uptime !== 32'd0) $display("FAIL reset_uptime got %0d want 0", bus.uptime); else pass_cnt++;
  endtask

  task automatic test_power_on();
    rst = 1'b1;
    tick(18);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL pwr_edge18 got %b want 0", bus.rst_sync_n); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_sync_n !== 1'b1) $display("FAIL pwr_edge19 got %b want 1", bus.rst_sync_n); else pass_cnt++;
    total_cnt++; if (bus.rst_done !== 1'b1) $display("FAIL pwr_done got %b want 1", bus.rst_done); else pass_cnt++;
    total_cnt++; if (bus.uptime !== 32'd1) $display("FAIL pwr_uptime1 got %0d want 1", bus.uptime); else pass_cnt++;
    total_cnt++; if (bus.clk_div !== 1'b1) $display("FAIL pwr_clk_div got %b want 1", bus.clk_div); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_done !== 1'b0) $display("FAIL pwr_done_pulse got %b want 0", bus.rst_done); else pass_cnt++;
    total_cnt++; if (bus.uptime !== 32'd2) $display("FAIL pwr_uptime2 got %0d want 2", bus.uptime); else pass_cnt++;
    tick(8);
    total_cnt++; if (bus.uptime !== 32'd10) $display("FAIL pwr_uptime10 got %0d want 10", bus.uptime); else pass_cnt++;
  endtask

  task automatic test_sw_reset();
    tick(3);
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL sw_low got %b want 0", bus.rst_sync_n); else pass_cnt++;
    total_cnt++; if (bus.uptime !== 32'd0) $display("FAIL sw_uptime0 got %0d want 0", bus.uptime); else pass_cnt++;
    tick(15);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL sw_low15 got %b want 0", bus.rst_sync_n); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_sync_n !== 1'b1) $display("FAIL sw_release got %b want 1", bus.rst_sync_n); else pass_cnt++;
    total_cnt++; if (bus.rst_done !== 1'b1) $display("FAIL sw_done got %b want 1", bus.rst_done); else pass_cnt++;
    total_cnt++; if (bus.uptime !== 32'd1) $display("FAIL sw_uptime1 got %0d want 1", bus.uptime); else pass_cnt++;
    // Held request keeps the block in HOLD; release counts from the last sampled request.
    bus.sw_rst_req = 1'b1;
    tick(20);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL sw_held got %b want 0", bus.rst_sync_n); else pass_cnt++;
    bus.sw_rst_req = 1'b0;
    tick(15);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL sw_held_15 got %b want 0", bus.rst_sync_n); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_sync_n !== 1'b1) $display("FAIL sw_held_release got %b want 1", bus.rst_sync_n); else pass_cnt++;
  endtask

  task automatic test_divider();
    logic [7:0] ns   [4] = '{8'd4, 8'd5, 8'd0, 8'd1};
    int         lens [4] = '{8, 10, 4, 4};
    logic [9:0] dpat [4] = '{10'h033, 10'h0E7, 10'h000, 10'h000};
    logic [9:0] epat [4] = '{10'h088, 10'h210, 10'h00F, 10'h00F};
    for (int c = 0; c < 4; c++) begin
      bus.div_ratio  = ns[c];
      bus.sw_rst_req = 1'b1;
      tick(1);
      bus.sw_rst_req = 1'b0;
      tick(16);
      for (int i = 0; i < lens[c]; i++) begin
        total_cnt++;
        if (bus.clk_div !== dpat[c][i] || bus.clk_div_en !== epat[c][i])
          $display("FAIL div_n%0d_cyc%0d got div=%b en=%b want div=%b en=%b",
                   ns[c], i, bus.clk_div, bus.clk_div_en, dpat[c][i], epat[c][i]);
        else pass_cnt++;
        tick(1);
      end
    end
  endtask

  task automatic test_div_change();
    logic [8:0] dexp = 9'h039;
    logic [8:0] eexp = 9'h104;
    bus.div_ratio  = 8'd4;
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(17);
    bus.div_ratio = 8'd6;
    for (int j = 0; j < 9; j++) begin
      total_cnt++;
      if (bus.clk_div !== dexp[j] || bus.clk_div_en !== eexp[j])
        $display("FAIL div_change_cyc%0d got div=%b en=%b want div=%b en=%b",
                 j + 1, bus.clk_div, bus.clk_div_en, dexp[j], eexp[j]);
      else pass_cnt++;
      tick(1);
    end
  endtask

  task automatic test_async_reset();
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(4);
    #3 rst = 1'b0;
    #1;
    total_cnt++; if (bus.rst_sync_n !== 1'b0 || bus.uptime !== 32'd0)
      $display("FAIL async_hold got rst_sync_n=%b uptime=%0d want 0 0", bus.rst_sync_n, bus.uptime); else pass_cnt++;
    rst = 1'b1;
    tick(18);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL async_hold_edge18 got %b want 0", bus.rst_sync_n); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_sync_n !== 1'b1 || bus.rst_done !== 1'b1)
      $display("FAIL async_hold_edge19 got rst_sync_n=%b done=%b want 1 1", bus.rst_sync_n, bus.rst_done); else pass_cnt++;
    tick(5);
    total_cnt++; if (bus.uptime !== 32'd6 || bus.clk_div_en !== 1'b1)
      $display("FAIL async_run_pre got uptime=%0d en=%b want 6 1", bus.uptime, bus.clk_div_en); else pass_cnt++;
    #3 rst = 1'b0;
    #1;
    total_cnt++; if (bus.rst_sync_n !== 1'b0 || bus.uptime !== 32'd0 || bus.clk_div_en !== 1'b0 || bus.rst_done !== 1'b0)
      $display("FAIL async_run got rst_sync_n=%b uptime=%0d en=%b done=%b want 0 0 0 0",
               bus.rst_sync_n, bus.uptime, bus.clk_div_en, bus.rst_done); else pass_cnt++;
    rst = 1'b1;
    tick(18);
    total_cnt++; if (bus.rst_sync_n !== 1'b0) $display("FAIL async_run_edge18 got %b want 0", bus.rst_sync_n); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.rst_sync_n !== 1'b1 || bus.uptime !== 32'd1)
      $display("FAIL async_run_edge19 got rst_sync_n=%b uptime=%0d want 1 1", bus.rst_sync_n, bus.uptime); else pass_cnt++;
  endtask

  task automatic test_saturation();
    bus4.sw_rst_req = 1'b1;
    tick(1);
    bus4.sw_rst_req = 1'b0;
    total_cnt++; if (bus4.uptime !== 4'd0) $display("FAIL sat_cleared got %0d want 0", bus4.uptime); else pass_cnt++;
    tick(16);
    total_cnt++; if (bus4.uptime !== 4'd1) $display("FAIL sat_start got %0d want 1", bus4.uptime); else pass_cnt++;
    tick(13);
    total_cnt++; if (bus4.uptime !== 4'd14) $display("FAIL sat_14 got %0d want 14", bus4.uptime); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus4.uptime !== 4'd15) $display("FAIL sat_15 got %0d want 15", bus4.uptime); else pass_cnt++;
    tick(10);
    total_cnt++; if (bus4.uptime !== 4'd15) $display("FAIL sat_hold got %0d want 15", bus4.uptime); else pass_cnt++;
  endtask

  initial begin
    bus.sw_rst_req  = 1'b0;
    bus.div_ratio   = 8'd4;
    bus4.sw_rst_req = 1'b0;
    bus4.div_ratio  = 8'd1;
    test_reset();
    test_power_on();
    test_sw_reset();
    test_divider();
    test_div_change();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
